div_mnbit_seq: RTL
==================

// Module: div_mnbit_seq
// PURPOSE
//  Sequential restoring divider: M-bit unsigned dividend / N-bit unsigned divisor.
//  It produces one quotient bit per clock, so a division takes M iterations.
//  Inverse of the combinational M x N array multiplier in the arithmetic library.
//  Sits beside it in the datapath as the area-cheap divide unit behind a start/done handshake.
// PARAMETERS
//  M  4  dividend and quotient width in bits (M >= 2)
//  N  4  divisor and remainder width in bits (N >= 2)
// PORTS
//  clk    in   1    single clock; all state updates on the rising edge
//  rst_n  in   1    reset, asynchronous assert, active-low
//  start  in   1    request; sampled only when busy==0
//  a      in   M    dividend; captured on an accepted start
//  b      in   N    divisor; captured on an accepted start
//  quot   out  M    quotient; registered, held until the next accepted start completes
//  rem    out  N    remainder; registered, held like quot
//  busy   out  1    high from the cycle after an accepted start until done
//  done   out  1    one-cycle pulse; quot/rem are valid from this cycle on
//  dbz    out  1    divide-by-zero flag; exists only with DIV_DBZ_EN
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): state=IDLE; quot, rem, busy, done, dbz, count and all internal regs = 0.
//  States:
//   - IDLE: start=1 -> load Q<=a, D<=b, R<=0 (N+1 bits), count<=M-1; go to CALC.
//   - CALC, each cycle:
//     - T = {R[N-1:0], Q[M-1]}
//     - if T >= {1'b0,D}: R <= T - D and shift 1 into Q LSB
//     - else: R <= T and shift 0 into Q LSB
//     - count==0 -> go to DONE; else count <= count-1
//   - DONE: done=1 for exactly this cycle; quot<=Q and rem<=R[N-1:0] are written on the CALC->DONE edge.
//     Next state is IDLE, or CALC if start=1 (a new load happens the same way as from IDLE).
//  busy = (state==CALC). done = (state==DONE). Both are decoded from registered state, with no combinational path from inputs.
//  Latency: start high in cycle 0 -> CALC in cycles 1..M -> done in cycle M+1. Throughput is one division per M+1 cycles.
//  Handshake and boundaries:
//   - start while busy: ignored, with no effect on a/b capture or on the result.
//   - a/b changing after acceptance: no effect.
//   - R width: the compare and subtract use N+1 bits, so no overflow is possible. The remainder always satisfies rem < b for b != 0.
//   - Divisor 0, without the macro: the iteration runs normally, giving quot = all ones and rem = a[N-1:0] (truncated running remainder).
//   - Reset during CALC: the operation is aborted immediately. No done is produced, and outputs return to 0.
// CONFIGURATION
//  Macro: DIV_DBZ_EN
//  - Defined:
//    - The dbz port exists.
//    - An accepted start with b==0 bypasses CALC: IDLE/DONE -> DONE on the next edge, so done appears in cycle 1.
//    - On that edge quot <= all ones, rem <= a[N-1:0], dbz <= 1.
//    - dbz is cleared on the next accepted start with b!=0 and on reset.
//  - Undefined: no dbz port. Divide by zero takes the full M+1 cycles with the results stated above.
// TESTING  (M=4, N=4 unless stated)
//  1. Reset, then a=13, b=3, start=1 for 1 cycle -> done pulse in cycle 5 only; quot=4, rem=1; busy high in cycles 1-4.
//  2. a=15, b=1 -> quot=15, rem=0. a=0, b=7 -> quot=0, rem=0. a=7, b=9 -> quot=0, rem=7.
//  3. a=13, b=3, then start again in cycle 2 with a=6, b=2 -> ignored; done in cycle 5 with quot=4, rem=1; no second done.
//  4. Back-to-back: start held high -> the DONE cycle accepts the next operands; done at cycles 5, 10, ...; all results correct.
//  5. Reset asserted in cycle 3 of a=13, b=3 -> quot=rem=busy=done=0 immediately; no done after release.
//  6. a=9, b=0:
//     - with DIV_DBZ_EN: done in cycle 1, dbz=1, quot=15, rem=9.
//     - without: done in cycle 5, quot=15, rem=9.
//  Plus a random sweep vs a reference model: M=8, N=5, 1000 divisions, checking quot == a/b and rem == a%b for b != 0.

Source files
------------

// File: rtl/div_mnbit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_mnbit_seq
//  Purpose  : Sequential restoring divider, M-bit unsigned dividend by N-bit
//             unsigned divisor. One quotient bit is produced per clock, so a
//             division spends M cycles in CALC behind a start/done handshake.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             start  - request, sampled only while not busy
//             a      - M-bit dividend, captured on an accepted start
//             b      - N-bit divisor, captured on an accepted start
//             quot   - M-bit registered quotient, held until next result
//             rem    - N-bit registered remainder, held like quot
//             busy   - high while iterating
//             done   - one-cycle pulse, quot/rem valid from this cycle on
//             dbz    - divide-by-zero flag (only with DIV_DBZ_EN)
//  Config   : DIV_DBZ_EN - adds dbz port and a one-cycle divide-by-zero path
//  Revision : 1.0 - initial release
// ============================================================================
module div_mnbit_seq #(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [N-1:0] b,
    output logic [M-1:0] quot,
    output logic [N-1:0] rem,
    output logic         busy,
    output logic         done
`ifdef DIV_DBZ_EN
    ,
    output logic         dbz
`endif
);

    localparam int              c_CW   = (M > 1) ? $clog2(M) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [M-1:0]    r_q;        // dividend shifting out, quotient shifting in
    logic [N-1:0]    r_d;        // captured divisor
    logic [N:0]      r_r;        // running remainder, one spare bit for the compare
    logic [c_CW-1:0] r_count;

    logic [N:0]      w_t;
    logic [N:0]      w_diff;
    logic [N:0]      w_r_nxt;
    logic [M-1:0]    w_q_nxt;
    logic            w_ge;
    logic            w_accept;
    logic            w_zero_div;

    // A new operation may be accepted from IDLE or in the DONE cycle.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef DIV_DBZ_EN
    localparam int   c_AW = (M > N) ? M : N;
    logic [c_AW-1:0] w_a_ext;

    // Zero-extend so rem can take a[N-1:0] even when N > M.
    assign w_a_ext    = c_AW'(a);
    assign w_zero_div = (b == '0);
`else
    assign w_zero_div = 1'b0;
`endif

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits.
    assign w_t     = {r_r[N-1:0], r_q[M-1]};
    assign w_ge    = (w_t >= {1'b0, r_d});
    assign w_diff  = w_t - {1'b0, r_d};
    assign w_r_nxt = w_ge ? w_diff : w_t;
    assign w_q_nxt = {r_q[M-2:0], w_ge};

    assign busy = (r_state == S_CALC);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (start) begin
                    w_state_nxt = w_zero_div ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_count <= '0;
            quot    <= '0;
            rem     <= '0;
`ifdef DIV_DBZ_EN
            dbz     <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_q     <= a;
                r_d     <= b;
                r_r     <= '0;
                r_count <= c_LAST;
`ifdef DIV_DBZ_EN
                // Divide by zero skips CALC; results land on this same edge.
                if (b == '0) begin
                    quot <= '1;
                    rem  <= w_a_ext[N-1:0];
                    dbz  <= 1'b1;
                end else begin
                    dbz  <= 1'b0;
                end
`endif
            end else if (r_state == S_CALC) begin
                r_q <= w_q_nxt;
                r_r <= w_r_nxt;
                if (r_count == '0) begin
                    // Publish the final step directly on the CALC->DONE edge.
                    quot <= w_q_nxt;
                    rem  <= w_r_nxt[N-1:0];
                end else begin
                    r_count <= r_count - c_CW'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
